// File: rtl/controle_movimento_pkg.sv
// Shared definitions for the square-motion controller and the collision stages.
package controle_movimento_pkg;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;

    typedef enum logic [1:0] {
        IDLE,
        SAMPLE,
        MOVE,
        SETTLE
    } estado_t;

    typedef enum logic [1:0] {
        DIR_UP,
        DIR_DOWN,
        DIR_LEFT,
        DIR_RIGHT
    } direcao_t;

    // Highest legal top-left coordinate on an axis; 0 when the square is
    // wider than the axis itself.
    function automatic logic [10:0] limite(input logic [10:0] extent, input logic [6:0] tam);
        logic [10:0] t;
        t = {4'd0, tam};
        return (t >= extent) ? 11'd0 : extent - t;
    endfunction

endpackage

// File: rtl/controle_movimento_divisor_tick.sv
// Free-running divider: one-cycle tick every STEP_DIV clocks.
module divisor_tick #(
    parameter int STEP_DIV = 833333
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);
    localparam int W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [W-1:0] ULTIMO = W'(STEP_DIV - 1);

    logic [W-1:0] cnt;

    assign tick = (cnt == ULTIMO);

    // Count 0..STEP_DIV-1 and wrap.
    always_ff @(posedge clk) begin
        if (reset)     cnt <= '0;
        else if (tick) cnt <= '0;
        else           cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/controle_movimento.sv
// Square position controller: one step per accepted movement tick, gated by
// collision flags, clamped to the visible area, then a settle window so the
// collision stages see the new position before the next step.
module controle_movimento
    import controle_movimento_pkg::*;
#(
    parameter int STEP_DIV   = 833333,
    parameter int PASSO      = 2,
    parameter int SETTLE_CYC = 2,
    parameter int X_INI      = 20,
    parameter int Y_INI      = 20,
    parameter int H_ACT      = H_ACTIVE,
    parameter int V_ACT      = V_ACTIVE
) (
    input  logic       VGA_clk,
    input  logic       reset,
    input  logic       key_up,
    input  logic       key_down,
    input  logic       key_left,
    input  logic       key_right,
    input  logic       colisao_min_y,
    input  logic       colisao_max_y,
    input  logic       colisao_min_x,
    input  logic       colisao_max_x,
    input  logic [6:0] tamanho,
    output logic [9:0] xPos,
    output logic [8:0] yPos,
    output logic       movendo,
    output logic       bloqueado
);
    localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [SW-1:0] SETTLE_FIM = SW'(SETTLE_CYC - 1);
    localparam logic [10:0]   PASSO11    = 11'(PASSO);
    localparam logic [10:0]   H11        = 11'(H_ACT);
    localparam logic [10:0]   V11        = 11'(V_ACT);

    logic tick;

    divisor_tick #(.STEP_DIV(STEP_DIV)) u_divisor (
        .clk   (VGA_clk),
        .reset (reset),
        .tick  (tick)
    );

    estado_t       estado, estado_n;
    direcao_t      dir, dir_n;
    logic [SW-1:0] settle_cnt, settle_cnt_n;
    logic [9:0]    x_n;
    logic [8:0]    y_n;
    logic          mov_n, blq_n;
    logic          tem_tecla, bloq_dir;
    logic [10:0]   x11, y11, soma, lim;

    assign x11 = {1'b0, xPos};
    assign y11 = {2'b0, yPos};

    // State, position and pulse registers.
    always_ff @(posedge VGA_clk) begin
        if (reset) begin
            estado     <= IDLE;
            dir        <= DIR_UP;
            settle_cnt <= '0;
            xPos       <= 10'(X_INI);
            yPos       <= 9'(Y_INI);
            movendo    <= 1'b0;
            bloqueado  <= 1'b0;
        end else begin
            estado     <= estado_n;
            dir        <= dir_n;
            settle_cnt <= settle_cnt_n;
            xPos       <= x_n;
            yPos       <= y_n;
            movendo    <= mov_n;
            bloqueado  <= blq_n;
        end
    end

    // Next state, direction latch and clamped step arithmetic.
    always_comb begin
        estado_n     = estado;
        dir_n        = dir;
        settle_cnt_n = settle_cnt;
        x_n          = xPos;
        y_n          = yPos;
        mov_n        = 1'b0;
        blq_n        = 1'b0;
        tem_tecla    = 1'b1;
        bloq_dir     = 1'b0;
        soma         = '0;
        lim          = '0;
        case (estado)
            IDLE: if (tick) estado_n = SAMPLE;
            SAMPLE: begin
                if (key_up) begin
                    dir_n = DIR_UP;    bloq_dir = colisao_min_y;
                end else if (key_down) begin
                    dir_n = DIR_DOWN;  bloq_dir = colisao_max_y;
                end else if (key_left) begin
                    dir_n = DIR_LEFT;  bloq_dir = colisao_min_x;
                end else if (key_right) begin
                    dir_n = DIR_RIGHT; bloq_dir = colisao_max_x;
                end else begin
                    tem_tecla = 1'b0;
                end
                if (!tem_tecla) begin
                    estado_n = IDLE;
                end else if (bloq_dir) begin
                    blq_n    = 1'b1;
                    estado_n = IDLE;
                end else begin
                    estado_n = MOVE;
                end
            end
            MOVE: begin
                case (dir)
                    DIR_UP:   y_n = (y11 < PASSO11) ? 9'd0 : 9'(y11 - PASSO11);
                    DIR_LEFT: x_n = (x11 < PASSO11) ? 10'd0 : 10'(x11 - PASSO11);
                    DIR_DOWN: begin
                        soma = y11 + PASSO11;
                        lim  = limite(V11, tamanho);
                        y_n  = 9'((soma < lim) ? soma : lim);
                    end
                    default: begin
                        soma = x11 + PASSO11;
                        lim  = limite(H11, tamanho);
                        x_n  = 10'((soma < lim) ? soma : lim);
                    end
                endcase
                mov_n        = (x_n != xPos) || (y_n != yPos);
                settle_cnt_n = '0;
                estado_n     = SETTLE;
            end
            default: begin
                if (settle_cnt == SETTLE_FIM) estado_n = IDLE;
                else                          settle_cnt_n = settle_cnt + 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_controle_movimento.sv
// Randomized bench for controle_movimento against a timeline-level model.
module tb_controle_movimento;
    localparam int SD = 4, P = 2, SC = 2, XI = 20, YI = 20, HA = 640, VA = 480;
    localparam int N_CYC = 12500;

    logic       clk = 1'b0;
    logic       reset;
    logic       key_up, key_down, key_left, key_right;
    logic       col_min_y, col_max_y, col_min_x, col_max_x;
    logic [6:0] tamanho;
    logic [9:0] xPos;
    logic [8:0] yPos;
    logic       movendo, bloqueado;

    int n_chk = 0, n_fail = 0;

    // model: edge index since reset, scheduled sample/move edges
    int k, sample_k, move_k, ready_k, m_dir;
    int mx, my, m_mov, m_blq;

    controle_movimento #(
        .STEP_DIV(SD), .PASSO(P), .SETTLE_CYC(SC), .X_INI(XI), .Y_INI(YI)
    ) dut (
        .VGA_clk(clk), .reset(reset),
        .key_up(key_up), .key_down(key_down), .key_left(key_left), .key_right(key_right),
        .colisao_min_y(col_min_y), .colisao_max_y(col_max_y),
        .colisao_min_x(col_min_x), .colisao_max_x(col_max_x),
        .tamanho(tamanho), .xPos(xPos), .yPos(yPos),
        .movendo(movendo), .bloqueado(bloqueado)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, obs, exp, k);
        end
    endtask

    // Behaviour at one clock edge, from the inputs present at that edge.
    task automatic model_edge();
        int lim;
        m_mov = 0;
        m_blq = 0;
        if (reset) begin
            mx = XI; my = YI; k = 0;
            sample_k = -1; move_k = -1; ready_k = 0;
            return;
        end
        k++;
        if (k == move_k) begin
            int ox, oy;
            ox = mx; oy = my;
            case (m_dir)
                0: my = (my < P) ? 0 : my - P;
                1: begin lim = (tamanho >= VA) ? 0 : VA - tamanho; my = (my + P < lim) ? my + P : lim; end
                2: mx = (mx < P) ? 0 : mx - P;
                default: begin lim = (tamanho >= HA) ? 0 : HA - tamanho; mx = (mx + P < lim) ? mx + P : lim; end
            endcase
            m_mov = (ox != mx || oy != my);
        end else if (k == sample_k) begin
            int blk;
            m_dir = -1;
            blk = 0;
            if (key_up)         begin m_dir = 0; blk = col_min_y; end
            else if (key_down)  begin m_dir = 1; blk = col_max_y; end
            else if (key_left)  begin m_dir = 2; blk = col_min_x; end
            else if (key_right) begin m_dir = 3; blk = col_max_x; end
            if (m_dir < 0 || blk != 0) begin
                m_blq   = blk;
                ready_k = k + 1;
            end else begin
                move_k  = k + 1;
                ready_k = k + 2 + SC;
            end
        end
        if (k % SD == 0 && k >= ready_k) begin
            sample_k = k + 1;
            ready_k  = 1 << 30;
        end
    endtask

    initial begin
        int phase, dom, rst_left;
        int tam_tab[5] = '{20, 21, 20, 127, 33};
        reset = 1'b1;
        {key_up, key_down, key_left, key_right} = '0;
        {col_min_y, col_max_y, col_min_x, col_max_x} = '0;
        tamanho = 7'd20;
        k = 0; sample_k = -1; move_k = -1; ready_k = 0; m_dir = 0;
        mx = XI; my = YI; m_mov = 0; m_blq = 0;
        rst_left = 3;
        for (int c = 0; c < N_CYC; c++) begin
            @(posedge clk);
            #1 model_edge();
            @(negedge clk);
            chk("xPos", int'(xPos), mx);
            chk("yPos", int'(yPos), my);
            chk("movendo", int'(movendo), m_mov);
            chk("bloqueado", int'(bloqueado), m_blq);
            // next inputs
            phase   = c / 2500;
            tamanho = 7'(tam_tab[phase]);
            if (rst_left > 0) rst_left--;
            else if ($urandom_range(599) == 0) rst_left = 3;
            reset = (rst_left > 0);
            if (phase < 4 && $urandom_range(99) < 85) begin
                dom = (phase == 0) ? 3 : (phase == 1) ? 1 : (phase == 2) ? 2 : 0;
                {key_up, key_down, key_left, key_right} = 4'b1000 >> dom;
            end else begin
                {key_up, key_down, key_left, key_right} = 4'($urandom_range(15));
            end
            col_min_y = ($urandom_range(9) == 0);
            col_max_y = ($urandom_range(9) == 0);
            col_min_x = ($urandom_range(9) == 0);
            col_max_x = ($urandom_range(9) == 0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
